mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Round-robin arbiter that lets NUM_REQ requesters share one memory port.
//   Only one transaction is in flight at a time. Each transaction passes
//   through IDLE -> ISSUE -> (WAIT ...) -> RESP -> IDLE.
//
// Ports
//   clk, rst        : clock, asynchronous active-low reset
//   req             : per-requester request, held until acked
//   req_wr          : per-requester direction (1 = write, 0 = read)
//   req_addr        : packed per-requester address, requester i in slice i
//   req_wdata       : packed per-requester write data
//   ack             : one-cycle completion pulse to the grantee
//   rdata           : read data, valid while ack is high
//   mem_rd_req      : one-cycle memory read command
//   mem_wr_req      : one-cycle memory write command
//   mem_addr        : latched command address
//   mem_wdata       : latched command write data
//   mem_ack         : memory completion
//   mem_rdata       : memory read data
//   busy            : high whenever the FSM is not in IDLE
//   grant_id        : index of the current grantee
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          mem_rd_req,
  output logic                          mem_wr_req,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic                          mem_ack,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic                          busy,
  output logic [IDW-1:0]                grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] pick;
  logic           wr_q;

  // First requesting index at or after ptr, wrapping modulo NUM_REQ.
  function automatic logic [IDW-1:0] arb_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [IDW-1:0]     ptr);
    logic [IDW-1:0] sel;
    logic           found;
    int             j;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && r[j]) begin
        found = 1'b1;
        sel   = IDW'(j);
      end
    end
    return sel;
  endfunction

  // Increment modulo NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] g);
    if (int'(g) >= NUM_REQ - 1) return '0;
    return g + IDW'(1);
  endfunction

  always_comb begin
    pick = arb_pick(req, rr_ptr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      wr_q       <= 1'b0;
      ack        <= '0;
      rdata      <= '0;
      mem_rd_req <= 1'b0;
      mem_wr_req <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      // Command and ack strobes are single-cycle unless re-asserted below.
      mem_rd_req <= 1'b0;
      mem_wr_req <= 1'b0;
      ack        <= '0;
      case (state)
        IDLE: begin
          // mem_ack is deliberately ignored here.
          if (|req) begin
            grant_id   <= pick;
            wr_q       <= req_wr[pick];
            mem_addr   <= req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata  <= req_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
            mem_rd_req <= !req_wr[pick];
            mem_wr_req <= req_wr[pick];
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          if (mem_ack) begin
            ack    <= ONE_HOT0 << grant_id;
            if (!wr_q) rdata <= mem_rdata;
            rr_ptr <= next_idx(grant_id);
            state  <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        RESP: begin
          // req and mem_ack are ignored; arbitration resumes from IDLE.
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR-1:0]    req_wr;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    ack;
  logic [DW-1:0]    rdata;
  logic             mem_rd_req;
  logic             mem_wr_req;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             mem_ack;
  logic [DW-1:0]    mem_rdata;
  logic             busy;
  logic [1:0]       grant_id;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .mem_rd_req(mem_rd_req),
    .mem_wr_req(mem_wr_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rq;
    logic [3:0]  wr;
    int          d;       // cycles after ISSUE before mem_ack (0 = in ISSUE)
    logic [31:0] md;      // mem_rdata supplied with mem_ack
    int          gid;     // expected grantee
    logic [31:0] exp_rd;  // expected rdata while ack is high
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int g);
    return 32'h100 * (g + 1);
  endfunction

  function automatic logic [31:0] exp_wdata(input int g);
    return 32'h53 + g;
  endfunction

  // Called at a negedge with the DUT in IDLE; returns at the negedge of the
  // IDLE cycle following RESP. req is left asserted through RESP.
  task automatic run_txn(input logic [3:0] rq, input logic [3:0] wr, input int d,
                         input logic [31:0] md, input int gid, input logic [31:0] exp_rd);
    logic [3:0] oh;
    oh      = 4'b0001 << gid;
    req     = rq;
    req_wr  = wr;
    mem_ack = 1'b0;
    @(negedge clk);  // ISSUE
    chk("issue_grant_id", grant_id, gid);
    chk("issue_busy", busy, 1'b1);
    chk("issue_rd_req", mem_rd_req, !wr[gid]);
    chk("issue_wr_req", mem_wr_req, wr[gid]);
    chk("issue_addr", mem_addr, exp_addr(gid));
    chk("issue_wdata", mem_wdata, exp_wdata(gid));
    chk("issue_ack", ack, 4'b0000);
    mem_rdata = 32'hBAD0_0000;
    if (d == 0) begin
      mem_ack   = 1'b1;
      mem_rdata = md;
    end
    for (int c = 1; c <= d; c++) begin
      @(negedge clk);  // WAIT
      chk("wait_cmd", {mem_rd_req, mem_wr_req}, 2'b00);
      chk("wait_busy", busy, 1'b1);
      chk("wait_ack", ack, 4'b0000);
      if (c == d) begin
        mem_ack   = 1'b1;
        mem_rdata = md;
      end
    end
    @(negedge clk);  // RESP
    mem_ack   = 1'b0;
    mem_rdata = 32'hFFFF_FFFF;
    chk("resp_ack", ack, oh);
    chk("resp_rdata", rdata, exp_rd);
    chk("resp_busy", busy, 1'b1);
    chk("resp_cmd", {mem_rd_req, mem_wr_req}, 2'b00);
    @(negedge clk);  // IDLE
    chk("idle_ack", ack, 4'b0000);
    chk("idle_busy", busy, 1'b0);
    chk("idle_addr_hold", mem_addr, exp_addr(gid));
    chk("idle_rdata_hold", rdata, exp_rd);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ack"}, ack, 4'b0000);
    chk({nm, "_rdata"}, rdata, 32'h0);
    chk({nm, "_cmd"}, {mem_rd_req, mem_wr_req}, 2'b00);
    chk({nm, "_addr"}, mem_addr, 32'h0);
    chk({nm, "_wdata"}, mem_wdata, 32'h0);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_grant_id"}, grant_id, 2'd0);
  endtask

  initial begin
    rst       = 1'b0;
    req       = '0;
    req_wr    = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]  = 32'h100 * (i + 1);
      req_wdata[i*DW +: DW] = 32'h53 + i;
    end

    //            rq       wr       d  md            gid exp_rd
    tbl[0]  = '{4'b0001, 4'b0000, 0, 32'h0000_DEAD, 0, 32'h0000_DEAD};
    tbl[1]  = '{4'b0100, 4'b0100, 5, 32'h0000_BEEF, 2, 32'h0000_DEAD};
    tbl[2]  = '{4'b1111, 4'b0000, 0, 32'h0000_1111, 3, 32'h0000_1111};
    tbl[3]  = '{4'b1111, 4'b0000, 0, 32'h0000_2222, 0, 32'h0000_2222};
    tbl[4]  = '{4'b1111, 4'b0000, 2, 32'h0000_3333, 1, 32'h0000_3333};
    tbl[5]  = '{4'b1111, 4'b1111, 0, 32'h0000_9999, 2, 32'h0000_3333};
    tbl[6]  = '{4'b1111, 4'b0000, 0, 32'h0000_4444, 3, 32'h0000_4444};
    tbl[7]  = '{4'b1111, 4'b0000, 0, 32'h0000_5555, 0, 32'h0000_5555};
    tbl[8]  = '{4'b0001, 4'b0000, 1, 32'h0000_6666, 0, 32'h0000_6666};
    tbl[9]  = '{4'b1010, 4'b0010, 0, 32'h0000_AAAA, 1, 32'h0000_6666};
    tbl[10] = '{4'b1010, 4'b0000, 0, 32'h0000_7777, 3, 32'h0000_7777};
    tbl[11] = '{4'b0110, 4'b0000, 3, 32'h0000_8888, 1, 32'h0000_8888};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", busy, 1'b0);

    // Table-driven transactions
    for (int v = 0; v < 12; v++) begin
      run_txn(tbl[v].rq, tbl[v].wr, tbl[v].d, tbl[v].md, tbl[v].gid, tbl[v].exp_rd);
    end

    // Spurious mem_ack in IDLE: nothing happens
    req       = '0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_5A5A;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("spur_busy", busy, 1'b0);
      chk("spur_ack", ack, 4'b0000);
      chk("spur_cmd", {mem_rd_req, mem_wr_req}, 2'b00);
      chk("spur_rdata", rdata, 32'h0000_8888);
    end
    mem_ack = 1'b0;

    // Sole requester holding req: back-to-back grants, no grant during RESP
    run_txn(4'b0010, 4'b0000, 0, 32'h0000_00A1, 1, 32'h0000_00A1);
    run_txn(4'b0010, 4'b0000, 0, 32'h0000_00A2, 1, 32'h0000_00A2);

    // Reset during WAIT aborts the transaction (rr_ptr is 2 here)
    req    = 4'b0100;
    req_wr = 4'b0100;
    @(negedge clk);  // ISSUE
    chk("abort_issue_wr", mem_wr_req, 1'b1);
    @(negedge clk);  // WAIT
    chk("abort_wait_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    chk_all_zero("held_reset");
    rst = 1'b1;
    run_txn(4'b1000, 4'b0000, 0, 32'h0000_C0DE, 3, 32'h0000_C0DE);

    req = '0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
